load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max BUSY cycles without bus_ack before error.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rw  in  2  from control: 00 none, 01 read, 10 write, 11 treated as none.
- func3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- rdata  out  32  aligned, extended load result to WB mux.
- lsu_stall  out  1  core holds PC/pipeline while high.
- lsu_err  out  1  one-cycle error pulse.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete.
- bus_rdata  in  32  read word.

Function
REQ-003 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-004 IDLE with mem_rw 01/10: SHALL register addr, func3, wdata and direction, then go to BUSY.
REQ-005 lsu_stall SHALL be combinational: high when mem_rw is 01/10 and state != DONE; low otherwise.
REQ-006 bus_req SHALL be high only in BUSY; bus_we/bus_addr/bus_be/bus_wdata SHALL stay stable from registered values while bus_req is high.
REQ-007 BUSY with bus_ack=1: SHALL capture formatted load data into rdata and go to DONE.
REQ-008 Minimum latency: request at cycle 0, bus_req at cycle 1, ack at cycle 1, DONE and lsu_stall low at cycle 2.
REQ-009 DONE SHALL last exactly one cycle; next state IDLE regardless of mem_rw.
REQ-010 Byte enables: B = 0001<<addr[1:0]; H = 0011<<{addr[1],1'b0}; W = 1111. func3[1:0]=11 SHALL be treated as W.
REQ-011 bus_wdata: B SHALL replicate wdata[7:0] to 4 lanes; H SHALL replicate wdata[15:0] to 2 lanes; W SHALL pass wdata unchanged.
REQ-012 Load data SHALL be bus_rdata >> (8*addr[1:0]), sign-extended if func3[2]=0, zero-extended if func3[2]=1; W SHALL ignore func3[2].
REQ-013 Stores SHALL leave rdata unchanged.
REQ-014 Timeout counter SHALL count BUSY cycles without ack. On reaching TIMEOUT: drop bus_req, pulse lsu_err, set rdata=0, go to DONE.
REQ-015 Counter SHALL clear on entry to BUSY.
REQ-016 bus_ack outside BUSY SHALL be ignored.
REQ-017 bus_ack in the same cycle as timeout SHALL win (normal completion, no error).

Reset
REQ-018 rst_n low SHALL immediately force state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, lsu_err=0, counter=0, including mid-transaction.
REQ-019 After rst_n rises, an in-flight transaction SHALL be abandoned, not replayed.

Configuration
REQ-020 With LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, SHALL issue no bus_req, go IDLE -> DONE next cycle, pulse lsu_err, set rdata=0.
REQ-021 Without LSU_MISALIGN_TRAP_EN: misaligned accesses SHALL ignore the offending low address bits (H uses addr[1] only; W uses lane 0); lsu_err SHALL assert only on timeout.

Structure
REQ-022 Package riscv_pkg SHALL hold memRW encodings (00/01/10), func3 size codes, and the LSU state enum.
REQ-023 Sub-module lsu_align (combinational byte-enable, store replication, load shift/extend) SHALL be instantiated once.

Verification
REQ-024 LW addr=0x100, bus_rdata=0xDEADBEEF, ack at cycle 1 -> rdata=0xDEADBEEF, lsu_stall low at cycle 2, bus_be=1111.
REQ-025 LB addr=0x103, bus_rdata=0x80xxxxxx -> rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-026 SH addr=0x102, wdata=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, rdata unchanged.
REQ-027 LW with no ack, TIMEOUT=16 -> bus_req drops after 16 BUSY cycles, lsu_err one-cycle pulse, rdata=0; ack on 16th cycle -> no error.
REQ-028 LW addr=0x101 -> with macro: no bus_req, lsu_err pulse, rdata=0; without macro: bus_addr=0x100, normal completion.
REQ-029 rst_n low during BUSY -> bus_req low same cycle, state IDLE; a later ack is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : riscv_pkg                                                   |
// | Purpose   : Shared encodings for the load/store path: memRW control     |
// |             codes, func3 access-size codes and the LSU state enum.      |
// |             Also provides the misalignment predicate that the           |
// |             optional trap uses.                                         |
// | Revision  : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package riscv_pkg;

  // memRW control encodings; 2'b11 is decoded as "no access"
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // func3 access-size codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size field, func3[1:0]; 2'b10 and 2'b11 both select a word
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_BUSY = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  // Halfword on an odd byte, or word not on a word boundary
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    r = 1'b0;
    if (f3[1:0] == SZ_H) r = a[0];
    else if (f3[1])      r = (a != 2'b00);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : lsu_align                                                   |
// | Purpose   : Combinational data alignment for the LSU: byte enables,     |
// |             store-lane replication and load shift/sign-extension.       |
// | Ports     : func3      in  3   access size / load extension             |
// |             addr_lo    in  2   byte offset within the word              |
// |             wdata      in  32  raw store data                           |
// |             bus_rdata  in  32  raw word read from the bus               |
// |             be         out 4   byte enables                             |
// |             wdata_rep  out 32  lane-replicated store data               |
// |             load_data  out 32  aligned and extended load data           |
// | Revision  : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [1:0]  off;
  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    // Word is the default; misaligned halfwords keep only addr[1] and
    // misaligned words stay on lane 0.
    off       = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata;
    case (func3[1:0])
      SZ_B: begin
        off       = addr_lo;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        off       = {addr_lo[1], 1'b0};
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase

    shifted = bus_rdata >> {off, 3'b000};
    sext    = ~func3[2];

    case (func3[1:0])
      SZ_B:    load_data = {{24{sext & shifted[7]}},  shifted[7:0]};
      SZ_H:    load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : load_store_unit                                             |
// | Purpose   : Single-outstanding load/store unit between the core and a   |
// |             simple req/ack memory bus. IDLE -> BUSY -> DONE -> IDLE,    |
// |             with a BUSY-cycle timeout that pulses lsu_err.              |
// | Params    : TIMEOUT  max BUSY cycles without bus_ack (default 16)       |
// | Config    : LSU_MISALIGN_TRAP_EN  when defined, misaligned H/W accesses |
// |             skip the bus, go straight to DONE and pulse lsu_err.        |
// | Ports     : clk, rst_n (async active-low)                               |
// |             mem_rw[1:0], func3[2:0], addr[31:0], wdata[31:0]  core in   |
// |             rdata[31:0], lsu_stall, lsu_err                   core out  |
// |             bus_req, bus_we, bus_addr, bus_be, bus_wdata      bus out   |
// |             bus_ack, bus_rdata                                bus in    |
// | Revision  : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_rw,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        lsu_stall,
  output logic        lsu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q, state_d;
  logic [31:0]      addr_q,  addr_d;
  logic [2:0]       func3_q, func3_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q,    we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q,   err_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic        req_valid;
  logic        misalign;
  logic        busy;
  logic [3:0]  be_w;
  logic [31:0] wdata_rep_w;
  logic [31:0] load_w;

  assign req_valid = (mem_rw == MEM_READ) || (mem_rw == MEM_WRITE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(func3, addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Alignment works from the registered request so the bus stays stable
  // for the whole BUSY phase.
  lsu_align u_align (
    .func3     (func3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .bus_rdata (bus_rdata),
    .be        (be_w),
    .wdata_rep (wdata_rep_w),
    .load_data (load_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      func3_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      func3_q <= func3_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    func3_d = func3_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;   // error is a single-cycle pulse

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          addr_d  = addr;
          func3_d = func3;
          wdata_d = wdata;
          we_d    = (mem_rw == MEM_WRITE);
          cnt_d   = '0;
          if (misalign) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        // Ack is checked first so an ack on the final allowed cycle
        // completes normally instead of timing out.
        if (bus_ack) begin
          if (!we_q) rdata_d = load_w;
          state_d = LSU_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  assign busy      = (state_q == LSU_BUSY);
  assign bus_req   = busy;
  assign bus_we    = busy & we_q;
  assign bus_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
  assign bus_be    = busy ? be_w : '0;
  assign bus_wdata = busy ? wdata_rep_w : '0;

  // Released in DONE so the core can advance on that cycle.
  assign lsu_stall = req_valid && (state_q != LSU_DONE);
  assign lsu_err   = err_q;
  assign rdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : tb_load_store_unit                                          |
// | Purpose   : Directed self-checking bench for load_store_unit:           |
// |             reset values, load/store formatting, timeout, late ack,     |
// |             stray ack, misaligned access and mid-transaction reset.     |
// | Revision  : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mem_rw;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        lsu_stall;
  logic        lsu_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rw    (mem_rw),
    .func3     (func3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .lsu_stall (lsu_stall),
    .lsu_err   (lsu_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access with ack on the first BUSY cycle. Entered and left
  // in IDLE, one time unit after a rising edge.
  task automatic xact(input string nm, input logic [1:0] rw, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                      input logic [3:0] ebe, input logic [31:0] ewd,
                      input logic [31:0] eaddr, input logic [31:0] erd);
    mem_rw = rw; func3 = f3; addr = a; wdata = wd;
    #1;
    chk({nm, " stall_idle"}, {31'd0, lsu_stall}, 32'd1);
    tick();
    chk({nm, " bus_req"},   {31'd0, bus_req}, 32'd1);
    chk({nm, " bus_we"},    {31'd0, bus_we}, {31'd0, (rw == 2'b10)});
    chk({nm, " bus_addr"},  bus_addr, eaddr);
    chk({nm, " bus_be"},    {28'd0, bus_be}, {28'd0, ebe});
    chk({nm, " bus_wdata"}, bus_wdata, ewd);
    bus_ack = 1'b1; bus_rdata = brd;
    tick();
    bus_ack = 1'b0;
    chk({nm, " stall_done"}, {31'd0, lsu_stall}, 32'd0);
    chk({nm, " req_done"},   {31'd0, bus_req}, 32'd0);
    chk({nm, " err"},        {31'd0, lsu_err}, 32'd0);
    chk({nm, " rdata"},      rdata, erd);
    mem_rw = 2'b00;
    tick();
  endtask

  initial begin
    mem_rw = 2'b00; func3 = 3'b000; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst rdata",     rdata, 32'd0);
    chk("rst bus_req",   {31'd0, bus_req}, 32'd0);
    chk("rst bus_we",    {31'd0, bus_we}, 32'd0);
    chk("rst bus_be",    {28'd0, bus_be}, 32'd0);
    chk("rst bus_addr",  bus_addr, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    chk("rst lsu_err",   {31'd0, lsu_err}, 32'd0);
    chk("rst lsu_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    //   name     rw     f3      addr          wdata         bus_rdata     be       bus_wdata     bus_addr      rdata
    xact("LW",    2'b01, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'h0000_0100, 32'hDEADBEEF);
    xact("LB",    2'b01, 3'b000, 32'h0000_0103, 32'h0,        32'h80123456, 4'b1000, 32'h0,        32'h0000_0100, 32'hFFFFFF80);
    xact("LBU",   2'b01, 3'b100, 32'h0000_0103, 32'h0,        32'h80123456, 4'b1000, 32'h0,        32'h0000_0100, 32'h00000080);
    xact("SH",    2'b10, 3'b001, 32'h0000_0102, 32'h1234ABCD, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0000_0100, 32'h00000080);
    xact("LH",    2'b01, 3'b001, 32'h0000_0102, 32'h0,        32'h9ABC0000, 4'b1100, 32'h0,        32'h0000_0100, 32'hFFFF9ABC);
    xact("LHU",   2'b01, 3'b101, 32'h0000_0206, 32'h0,        32'h9ABC1234, 4'b1100, 32'h0,        32'h0000_0204, 32'h00009ABC);
    xact("SB",    2'b10, 3'b000, 32'h0000_0301, 32'h7777775A, 32'h0,        4'b0010, 32'h5A5A5A5A, 32'h0000_0300, 32'h00009ABC);
    xact("SW",    2'b10, 3'b010, 32'h0000_0400, 32'hCAFEBABE, 32'h0,        4'b1111, 32'hCAFEBABE, 32'h0000_0400, 32'h00009ABC);
    xact("LBpos", 2'b01, 3'b000, 32'h0000_0401, 32'h0,        32'h00007F00, 4'b0010, 32'h0,        32'h0000_0400, 32'h0000007F);

    // Misaligned word load at 0x101
`ifdef LSU_MISALIGN_TRAP_EN
    mem_rw = 2'b01; func3 = 3'b010; addr = 32'h0000_0101; wdata = '0;
    #1;
    chk("MIS stall_idle", {31'd0, lsu_stall}, 32'd1);
    tick();
    chk("MIS bus_req", {31'd0, bus_req}, 32'd0);
    chk("MIS lsu_err", {31'd0, lsu_err}, 32'd1);
    chk("MIS rdata",   rdata, 32'd0);
    chk("MIS stall",   {31'd0, lsu_stall}, 32'd0);
    mem_rw = 2'b00;
    tick();
    chk("MIS err_pulse", {31'd0, lsu_err}, 32'd0);
`else
    xact("LWmis", 2'b01, 3'b010, 32'h0000_0101, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h0,        32'h0000_0100, 32'hCAFEF00D);
    xact("SHmis", 2'b10, 3'b001, 32'h0000_0103, 32'h0000BEEF, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'h0000_0100, 32'hCAFEF00D);
`endif

    // Non-zero rdata so the timeout clear is observable
    xact("LWpre", 2'b01, 3'b010, 32'h0000_0500, 32'h0, 32'h13579BDF, 4'b1111, 32'h0, 32'h0000_0500, 32'h13579BDF);

    // Timeout: no ack for 16 BUSY cycles
    mem_rw = 2'b01; func3 = 3'b010; addr = 32'h0000_0600;
    tick();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("TO req_c%0d", k), {31'd0, bus_req}, 32'd1);
      tick();
    end
    chk("TO req_drop", {31'd0, bus_req}, 32'd0);
    chk("TO lsu_err",  {31'd0, lsu_err}, 32'd1);
    chk("TO rdata",    rdata, 32'd0);
    chk("TO stall",    {31'd0, lsu_stall}, 32'd0);
    mem_rw = 2'b00;
    tick();
    chk("TO err_pulse", {31'd0, lsu_err}, 32'd0);

    // Ack on the 16th BUSY cycle wins over the timeout
    mem_rw = 2'b01; func3 = 3'b010; addr = 32'h0000_0700;
    tick();
    for (int k = 1; k <= 15; k++) tick();
    chk("ACK16 req", {31'd0, bus_req}, 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h24681357;
    tick();
    bus_ack = 1'b0;
    chk("ACK16 err",   {31'd0, lsu_err}, 32'd0);
    chk("ACK16 rdata", rdata, 32'h24681357);
    chk("ACK16 req_drop", {31'd0, bus_req}, 32'd0);
    mem_rw = 2'b00;
    tick();

    // Stray ack while IDLE is ignored
    bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
    tick();
    tick();
    bus_ack = 1'b0;
    chk("STRAY rdata", rdata, 32'h24681357);
    chk("STRAY req",   {31'd0, bus_req}, 32'd0);
    chk("STRAY err",   {31'd0, lsu_err}, 32'd0);

    // Reset during BUSY, then a late ack
    mem_rw = 2'b01; func3 = 3'b010; addr = 32'h0000_0800;
    tick();
    chk("RST busy_req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("RST req_now",  {31'd0, bus_req}, 32'd0);
    chk("RST be_now",   {28'd0, bus_be}, 32'd0);
    chk("RST addr_now", bus_addr, 32'd0);
    chk("RST rdata",    rdata, 32'd0);
    mem_rw = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    tick();
    bus_ack = 1'b0;
    chk("RST late_ack_rdata", rdata, 32'd0);
    chk("RST late_ack_req",   {31'd0, bus_req}, 32'd0);
    chk("RST late_ack_err",   {31'd0, lsu_err}, 32'd0);
    chk("RST no_replay",      {31'd0, lsu_stall}, 32'd0);
    tick();

    xact("LWpost", 2'b01, 3'b010, 32'h0000_0900, 32'h0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0000_0900, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
